// File: rtl/axis_pkg.sv
// axis_pkg
// Shared definitions for the AXI4-Stream frame demultiplexer slice.
//   - Frame-tracking state encodings (IDLE / FWD / DROP), kept as plain
//     2-bit constants so older tools can consume them.
//   - sel_width(): select-width helper that never returns zero, so a
//     port-index vector is always at least one bit wide.
package axis_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_FWD  = 2'd1;
    localparam logic [1:0] STATE_DROP = 2'd2;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg
// Output stage of the frame demultiplexer.
// It holds one beat (payload plus destination port index) and presents it
// downstream with a valid/ready handshake.
//
// Build option AXIS_FRAME_DEMUX_SKID_EN:
//   defined   - 2-entry skid buffer. in_ready is a register output, so there
//               is no combinational path from out_ready.
//   undefined - single register. in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid       beat to load (already qualified by the upstream handshake)
//   in_ready       stage can take a beat this cycle
//   in_payload     packed data/sideband/last
//   in_port        destination port of the incoming beat
//   out_valid      stage holds a beat for downstream
//   out_ready      ready of the port the held beat is addressed to
//   out_payload    held payload
//   out_port       held destination port
module axis_out_reg #(
    parameter int PAYLOAD_WIDTH = 8,
    parameter int PORT_WIDTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    input  logic [PORT_WIDTH-1:0]    in_port,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [PORT_WIDTH-1:0]    out_port
);

    logic                     main_valid;
    logic [PAYLOAD_WIDTH-1:0] main_payload;
    logic [PORT_WIDTH-1:0]    main_port;

    assign out_valid   = main_valid;
    assign out_payload = main_payload;
    assign out_port    = main_port;

`ifdef AXIS_FRAME_DEMUX_SKID_EN
    logic                     skid_valid;
    logic [PAYLOAD_WIDTH-1:0] skid_payload;
    logic [PORT_WIDTH-1:0]    skid_port;

    // Ready only depends on skid occupancy, which is a flop.
    // A beat accepted while the main register is stalled parks in the skid
    // entry. The skid entry always refills the main register before any new
    // input, which keeps beats in order.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid   <= 1'b0;
            main_payload <= '0;
            main_port    <= '0;
            skid_valid   <= 1'b0;
            skid_payload <= '0;
            skid_port    <= '0;
        end else if (!main_valid || out_ready) begin
            if (skid_valid) begin
                main_valid   <= 1'b1;
                main_payload <= skid_payload;
                main_port    <= skid_port;
                skid_valid   <= 1'b0;
            end else begin
                main_valid <= in_valid;
                if (in_valid) begin
                    main_payload <= in_payload;
                    main_port    <= in_port;
                end
            end
        end else if (in_valid) begin
            skid_valid   <= 1'b1;
            skid_payload <= in_payload;
            skid_port    <= in_port;
        end
    end
`else
    // The register can take a beat when it is empty or its beat leaves this cycle.
    assign in_ready = !main_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid   <= 1'b0;
            main_payload <= '0;
            main_port    <= '0;
        end else if (in_ready) begin
            main_valid <= in_valid;
            if (in_valid) begin
                main_payload <= in_payload;
                main_port    <= in_port;
            end
        end
    end
`endif

endmodule

// File: rtl/axis_frame_demux.sv
// axis_frame_demux
// Frame-aware AXI4-Stream demultiplexer.
// The destination port is latched from sel on the first beat of each frame
// and held until tlast. A frame can be discarded whole by asserting drop on
// its first beat, or by selecting a port that does not exist.
// Output data and sideband are replicated to every port. Only the tvalid of
// the addressed port is raised.
//
// Build option AXIS_FRAME_DEMUX_SKID_EN (see axis_out_reg) selects a skid
// buffer output with registered s_axis_tready instead of a single register.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   s_axis_*                    input stream (tready is an output)
//   m_axis_tdata/tkeep/tid/...  replicated output payload, M_COUNT copies
//   m_axis_tvalid               one-hot per-port valid
//   m_axis_tready               per-port ready
//   enable                      allow a new frame to start
//   drop                        discard the frame starting on this beat
//   sel                         destination port, sampled at frame start
module axis_frame_demux
    import axis_pkg::*;
#(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    input  logic [ID_WIDTH-1:0]              s_axis_tid,
    input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
    input  logic [USER_WIDTH-1:0]            s_axis_tuser,
    output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic [M_COUNT-1:0]               m_axis_tvalid,
    input  logic [M_COUNT-1:0]               m_axis_tready,
    output logic [M_COUNT-1:0]               m_axis_tlast,
    output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
    output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
    output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,
    input  logic                             enable,
    input  logic                             drop,
    input  logic [$clog2(M_COUNT)-1:0]       sel
);

    localparam int SEL_W         = sel_width(M_COUNT);
    localparam int PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH
                                 + DEST_WIDTH + USER_WIDTH + 1;

    logic [1:0]               state_q;
    logic [1:0]               state_d;
    logic [SEL_W-1:0]         port_q;
    logic                     sel_exists;
    logic                     ready_raw;
    logic                     fire;
    logic                     fwd_valid;
    logic [SEL_W-1:0]         beat_port;
    logic                     reg_in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [SEL_W-1:0]         out_port;
    logic [PAYLOAD_WIDTH-1:0] in_payload;
    logic [PAYLOAD_WIDTH-1:0] out_payload;

    logic [KEEP_WIDTH-1:0]    keep_v;
    logic [ID_WIDTH-1:0]      id_v;
    logic [DEST_WIDTH-1:0]    dest_v;
    logic [USER_WIDTH-1:0]    user_v;

    logic [DATA_WIDTH-1:0]    out_data;
    logic [KEEP_WIDTH-1:0]    out_keep;
    logic [ID_WIDTH-1:0]      out_id;
    logic [DEST_WIDTH-1:0]    out_dest;
    logic [USER_WIDTH-1:0]    out_user;
    logic                     out_last;

    // A sel value only names a real port when it matches one of 0..M_COUNT-1.
    // The loop avoids a constant-range compare when M_COUNT is a power of two.
    always_comb begin
        sel_exists = 1'b0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_exists = 1'b1;
            end
        end
    end

    // Input ready: a frame start needs enable plus room in the output stage.
    // Mid-frame forwarding needs only room. Discarding never stalls.
    // Ready is forced low while reset is held.
    always_comb begin
        ready_raw = 1'b0;
        beat_port = port_q;
        fwd_valid = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                ready_raw = enable && reg_in_ready;
                beat_port = sel;
                fwd_valid = fire && !drop && sel_exists;
            end
            STATE_FWD: begin
                ready_raw = reg_in_ready;
                fwd_valid = fire;
            end
            STATE_DROP: begin
                ready_raw = 1'b1;
            end
            default: begin
                ready_raw = 1'b0;
            end
        endcase
    end

    assign s_axis_tready = ready_raw && !rst;
    assign fire          = s_axis_tvalid && s_axis_tready;

    // Frame tracking. A single-beat frame (tlast on the first beat) never
    // leaves IDLE, whether it is forwarded or discarded.
    always_comb begin
        state_d = state_q;
        if (fire) begin
            case (state_q)
                STATE_IDLE: begin
                    if (!s_axis_tlast) begin
                        state_d = (drop || !sel_exists) ? STATE_DROP : STATE_FWD;
                    end
                end
                STATE_FWD, STATE_DROP: begin
                    if (s_axis_tlast) begin
                        state_d = STATE_IDLE;
                    end
                end
                default: begin
                    state_d = STATE_IDLE;
                end
            endcase
        end
    end

    // The port is latched only on an accepted frame-start beat.
    // This is why a sel change during the tlast beat only affects the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            port_q  <= '0;
        end else begin
            state_q <= state_d;
            if (fire && (state_q == STATE_IDLE)) begin
                port_q <= sel;
            end
        end
    end

    // Disabled sidebands are carried as constants: tkeep all-ones, others zero.
    always_comb begin
        keep_v = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
        id_v   = (ID_ENABLE   != 0) ? s_axis_tid   : '0;
        dest_v = (DEST_ENABLE != 0) ? s_axis_tdest : '0;
        user_v = (USER_ENABLE != 0) ? s_axis_tuser : '0;
    end

    assign in_payload = {s_axis_tdata, keep_v, id_v, dest_v, user_v, s_axis_tlast};

    axis_out_reg #(
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
        .PORT_WIDTH    (SEL_W)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (fwd_valid),
        .in_ready    (reg_in_ready),
        .in_payload  (in_payload),
        .in_port     (beat_port),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .out_port    (out_port)
    );

    assign out_ready = m_axis_tready[out_port];
    assign {out_data, out_keep, out_id, out_dest, out_user, out_last} = out_payload;

    // Replicate the held beat to every port. Only the addressed port's valid is raised.
    always_comb begin
        for (int i = 0; i < M_COUNT; i++) begin
            m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = out_data;
            m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] = out_keep;
            m_axis_tid[i*ID_WIDTH +: ID_WIDTH]       = out_id;
            m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH] = out_dest;
            m_axis_tuser[i*USER_WIDTH +: USER_WIDTH] = out_user;
            m_axis_tlast[i]                          = out_last;
            m_axis_tvalid[i]                         = out_valid && (out_port == SEL_W'(i));
        end
    end

endmodule

// File: tb/tb_axis_frame_demux.sv
// tb_axis_frame_demux
// Directed self-checking bench for axis_frame_demux with default parameters:
// 4 ports, 8-bit data, tuser enabled, and tkeep/tid/tdest disabled.
// Inputs change 1 ns after the rising edge. Outputs are observed on the
// falling edge. A negedge monitor checks every delivered beat against an
// expected queue, which is filled with hand-chosen ports and data.
module tb_axis_frame_demux;

    localparam int M  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_axis_tdata;
    logic [0:0]      s_axis_tkeep;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [7:0]      s_axis_tid;
    logic [7:0]      s_axis_tdest;
    logic [0:0]      s_axis_tuser;
    logic [M*DW-1:0] m_axis_tdata;
    logic [M-1:0]    m_axis_tkeep;
    logic [M-1:0]    m_axis_tvalid;
    logic [M-1:0]    m_axis_tready;
    logic [M-1:0]    m_axis_tlast;
    logic [M*8-1:0]  m_axis_tid;
    logic [M*8-1:0]  m_axis_tdest;
    logic [M-1:0]    m_axis_tuser;
    logic            enable;
    logic            drop;
    logic [1:0]      sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int port;
        int data;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    bit    stall_mode = 1'b0;

    axis_frame_demux dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser),
        .enable        (enable),
        .drop          (drop),
        .sel           (sel)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one input beat, then wait (bounded) for it to be accepted.
    // expPort < 0 means the beat must not appear on any output.
    task automatic applyStimulus(input logic [7:0] data, input bit last, input logic [1:0] s,
                                 input bit d, input bit en, input int expPort, output int waited);
        bit    got;
        beat_t b;
        got           = 1'b0;
        waited        = 0;
        s_axis_tdata  = data;
        s_axis_tuser  = data[0];
        s_axis_tlast  = last;
        sel           = s;
        drop          = d;
        enable        = en;
        s_axis_tvalid = 1'b1;
        while (!got && waited < 200) begin
            @(negedge clk);
            if (s_axis_tready) got = 1'b1;
            else waited++;
        end
        if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (got && expPort >= 0) begin
            b.port = expPort;
            b.data = int'(data);
            b.last = last;
            exp_q.push_back(b);
        end
        s_axis_tvalid = 1'b0;
    endtask

    // Port 2 ready toggles pseudo-randomly while stall_mode is set.
    initial begin
        m_axis_tready = 4'hF;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) m_axis_tready = {1'b1, 1'($urandom_range(0, 1)), 2'b11};
            else            m_axis_tready = 4'hF;
        end
    end

    // Output monitor: one-hot valid, in-order delivery, and stability under stall.
    initial begin
        bit         stalled_prev;
        int         stall_port;
        logic [7:0] stall_data;
        beat_t      e;
        stalled_prev = 1'b0;
        stall_port   = 0;
        stall_data   = '0;
        forever begin
            @(negedge clk);
            if (stalled_prev) begin
                checkOutput("stall_valid", 32'(m_axis_tvalid[stall_port]), 32'd1);
                checkOutput("stall_data", 32'(m_axis_tdata[stall_port*8 +: 8]), 32'(stall_data));
            end
            stalled_prev = 1'b0;
            if (m_axis_tvalid != '0) begin
                checkOutput("onehot", 32'($countones(m_axis_tvalid)), 32'd1);
                for (int i = 0; i < M; i++) begin
                    if (m_axis_tvalid[i]) begin
                        if (m_axis_tready[i]) begin
                            if (exp_q.size() == 0) begin
                                checkOutput("unexpected_beat_port", 32'(i), 32'hFF);
                            end else begin
                                e = exp_q.pop_front();
                                checkOutput("port", 32'(i), 32'(e.port));
                                checkOutput("tdata", 32'(m_axis_tdata[i*8 +: 8]), 32'(e.data));
                                checkOutput("tlast", 32'(m_axis_tlast[i]), 32'(e.last));
                                checkOutput("tuser", 32'(m_axis_tuser[i]), 32'(e.data & 1));
                                checkOutput("tkeep", 32'(m_axis_tkeep[i]), 32'd1);
                                checkOutput("tid_tdest", {m_axis_tid[i*8 +: 8], m_axis_tdest[i*8 +: 8]}, 32'd0);
                            end
                        end else begin
                            stalled_prev = 1'b1;
                            stall_port   = i;
                            stall_data   = m_axis_tdata[i*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        rst           = 1'b1;
        s_axis_tdata  = 8'hAA;
        s_axis_tkeep  = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tid    = 8'h5A;
        s_axis_tdest  = 8'hA5;
        s_axis_tuser  = 1'b0;
        enable        = 1'b1;
        drop          = 1'b0;
        sel           = 2'd0;

        // Reset: no output valid, no input ready even with valid+enable asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_tready", 32'(s_axis_tready), 32'd0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;

        // enable=0 in IDLE: nothing accepted
        s_axis_tvalid = 1'b1;
        enable        = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("en0_tready", 32'(s_axis_tready), 32'd0);
            checkOutput("en0_tvalid", 32'(m_axis_tvalid), 32'd0);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        enable        = 1'b1;

        // Single-beat frames to each port; one cycle latency, one-hot valid
        for (int s = 0; s < M; s++) begin
            applyStimulus(8'h10 + 8'(s), 1'b1, 2'(s), 1'b0, 1'b1, s, w);
            checkOutput("latency_onehot", 32'(m_axis_tvalid), 32'(4'b0001 << s));
        end

        // 4-beat frame to port 1, sel changed mid-frame; next frame goes to 3
        applyStimulus(8'h20, 1'b0, 2'd1, 1'b0, 1'b1, 1, w);
        applyStimulus(8'h21, 1'b0, 2'd1, 1'b0, 1'b1, 1, w);
        applyStimulus(8'h22, 1'b0, 2'd3, 1'b0, 1'b1, 1, w);
        applyStimulus(8'h23, 1'b1, 2'd3, 1'b0, 1'b1, 1, w);
        applyStimulus(8'h30, 1'b1, 2'd3, 1'b0, 1'b1, 3, w);
        checkOutput("next_frame_port3", 32'(m_axis_tvalid), 32'h8);

        // Dropped 3-beat frame: accepted immediately, no output activity
        applyStimulus(8'h40, 1'b0, 2'd0, 1'b1, 1'b1, -1, w);
        checkOutput("drop_wait0", 32'(w), 32'd0);
        checkOutput("drop_novalid0", 32'(m_axis_tvalid), 32'd0);
        applyStimulus(8'h41, 1'b0, 2'd1, 1'b0, 1'b0, -1, w);
        checkOutput("drop_wait1", 32'(w), 32'd0);
        checkOutput("drop_novalid1", 32'(m_axis_tvalid), 32'd0);
        applyStimulus(8'h42, 1'b1, 2'd1, 1'b0, 1'b0, -1, w);
        checkOutput("drop_wait2", 32'(w), 32'd0);
        checkOutput("drop_novalid2", 32'(m_axis_tvalid), 32'd0);
        applyStimulus(8'h50, 1'b1, 2'd2, 1'b0, 1'b1, 2, w);
        checkOutput("after_drop_port2", 32'(m_axis_tvalid), 32'h4);

        // 16-beat frame to port 2 with its ready toggling; later sel values ignored
        stall_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i), (i == 15), (i == 0) ? 2'd2 : 2'(i), 1'b0, 1'b1, 2, w);
        end
        repeat (40) @(posedge clk);
        stall_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // enable dropped mid-frame: frame still completes on port 0
        applyStimulus(8'h60, 1'b0, 2'd0, 1'b0, 1'b1, 0, w);
        applyStimulus(8'h61, 1'b0, 2'd3, 1'b0, 1'b0, 0, w);
        applyStimulus(8'h62, 1'b1, 2'd3, 1'b0, 1'b0, 0, w);
        enable = 1'b1;

        // Reset after beat 2 of a 5-beat frame; the rest starts a new frame on port 2
        applyStimulus(8'h70, 1'b0, 2'd1, 1'b0, 1'b1, 1, w);
        applyStimulus(8'h71, 1'b0, 2'd1, 1'b0, 1'b1, 1, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        rst = 1'b0;
        applyStimulus(8'h72, 1'b0, 2'd2, 1'b0, 1'b1, 2, w);
        applyStimulus(8'h73, 1'b0, 2'd1, 1'b0, 1'b1, 2, w);
        applyStimulus(8'h74, 1'b1, 2'd1, 1'b0, 1'b1, 2, w);

        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
